// File: rtl/ram_pkg.sv
// Shared constants for the multi-chip RAM bank: bus cycle numbers, field widths and the
// RAM I/O opcodes.
package ram_pkg;

    localparam int unsigned CHAR_W = 4;
    localparam int unsigned REG_W  = 2;

    localparam logic [2:0] CYC_INST = 3'd4;
    localparam logic [2:0] CYC_SRC  = 3'd6;
    localparam logic [2:0] CYC_EXEC = 3'd6;
    localparam logic [2:0] CYC_ADDR = 3'd7;

    localparam logic [3:0] OP_WRM = 4'h0;
    localparam logic [3:0] OP_WMP = 4'h1;
    localparam logic [3:0] OP_WR0 = 4'h4;
    localparam logic [3:0] OP_WR1 = 4'h5;
    localparam logic [3:0] OP_WR2 = 4'h6;
    localparam logic [3:0] OP_WR3 = 4'h7;
    localparam logic [3:0] OP_SBM = 4'h8;
    localparam logic [3:0] OP_RDM = 4'h9;
    localparam logic [3:0] OP_ADM = 4'hB;
    localparam logic [3:0] OP_RD0 = 4'hC;
    localparam logic [3:0] OP_RD1 = 4'hD;
    localparam logic [3:0] OP_RD2 = 4'hE;
    localparam logic [3:0] OP_RD3 = 4'hF;

endpackage

// File: rtl/ram_bank_if.sv
// Control and port signals between the CPU bus and the RAM bank. The 4-bit data bus is
// tristate and stays a plain inout port on the bank.
interface ram_bank_if #(
    parameter int unsigned NUM_CHIPS = 4
);

    logic                   sync;
    logic                   cmd_n;
    logic                   p0;
    logic [4*NUM_CHIPS-1:0] out;
    logic                   data_oe;

    modport master (
        output sync, cmd_n, p0,
        input  out, data_oe
    );

    modport slave (
        input  sync, cmd_n, p0,
        output out, data_oe
    );

endinterface

// File: rtl/ram_bank_decode.sv
// Combinational decode of a latched RAM I/O opcode into write/drive strobes.
module ram_bank_decode
    import ram_pkg::*;
(
    input  logic [3:0] inst,
    output logic       write_ram,
    output logic       write_port,
    output logic       write_status,
    output logic       ram_to_data,
    output logic       status_to_data,
    output logic [1:0] status_idx
);

    always_comb begin
        write_ram      = 1'b0;
        write_port     = 1'b0;
        write_status   = 1'b0;
        ram_to_data    = 1'b0;
        status_to_data = 1'b0;
        // WRn and RDn both carry the status character index in the low two bits
        status_idx     = inst[1:0];
        case (inst)
            OP_WRM:                         write_ram      = 1'b1;
            OP_WMP:                         write_port     = 1'b1;
            OP_WR0, OP_WR1, OP_WR2, OP_WR3: write_status   = 1'b1;
            OP_SBM, OP_RDM, OP_ADM:         ram_to_data    = 1'b1;
            OP_RD0, OP_RD1, OP_RD2, OP_RD3: status_to_data = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/ram_bank.sv
// Bank of NUM_CHIPS emulated 4-bit-bus RAM chips sharing one data bus.
// Define RAM_RESET_CLEAR_EN to have reset zero the data and status memories.
module ram_bank
    import ram_pkg::*;
#(
    parameter int unsigned NUM_CHIPS    = 4,
    parameter bit          BANK_P0      = 1'b0,
    parameter int unsigned STATUS_CHARS = 4
) (
    input  logic       clock,
    input  logic       reset,
    inout  wire  [3:0] data,
    ram_bank_if.slave  bus
);

    localparam int unsigned MEM_DEPTH = NUM_CHIPS * 4 * 16;
    localparam int unsigned ST_DEPTH  = NUM_CHIPS * 4 * STATUS_CHARS;
    localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
    localparam int unsigned ST_AW     = $clog2(ST_DEPTH);

    logic [2:0]             phase_q;
    logic                   sel_valid_q;
    logic [1:0]             sel_chip_q;
    logic [REG_W-1:0]       reg_addr_q;
    logic [CHAR_W-1:0]      char_addr_q;
    logic [3:0]             inst_q;
    logic                   src_active_q;
    logic                   inst_active_q;
    logic [4*NUM_CHIPS-1:0] out_q;

    logic [CHAR_W-1:0] mem    [MEM_DEPTH];
    logic [CHAR_W-1:0] status [ST_DEPTH];

    logic       cmd;
    logic       bank_hit;
    logic       exec;
    logic       data_oe;
    logic [3:0] rd_data;
    logic       write_ram, write_port, write_status, ram_to_data, status_to_data;
    logic [1:0] status_idx;
    logic [MEM_AW-1:0] mem_addr;
    logic [ST_AW-1:0]  st_addr;

    ram_bank_decode u_decode (
        .inst           (inst_q),
        .write_ram      (write_ram),
        .write_port     (write_port),
        .write_status   (write_status),
        .ram_to_data    (ram_to_data),
        .status_to_data (status_to_data),
        .status_idx     (status_idx)
    );

    assign cmd      = ~bus.cmd_n;
    assign bank_hit = (bus.p0 == BANK_P0) && (32'(data[3:2]) < NUM_CHIPS);
    assign exec     = (phase_q == CYC_EXEC) && inst_active_q && sel_valid_q;
    assign mem_addr = MEM_AW'({sel_chip_q, reg_addr_q, char_addr_q});
    assign st_addr  = ST_AW'((int'(sel_chip_q) * 4 + int'(reg_addr_q)) * int'(STATUS_CHARS)
                             + int'(status_idx));

    always_ff @(posedge clock) begin
        if (reset) begin
            phase_q       <= 3'd0;
            sel_valid_q   <= 1'b0;
            sel_chip_q    <= 2'd0;
            reg_addr_q    <= 2'd3;
            char_addr_q   <= 4'd15;
            inst_q        <= 4'd0;
            src_active_q  <= 1'b0;
            inst_active_q <= 1'b0;
            out_q         <= '0;
        end else begin
            phase_q <= bus.sync ? 3'd0 : phase_q + 3'd1;

            if (cmd && phase_q == CYC_SRC) begin
                if (bank_hit) begin
                    sel_valid_q  <= 1'b1;
                    sel_chip_q   <= data[3:2];
                    reg_addr_q   <= data[1:0];
                    src_active_q <= 1'b1;
                end else begin
                    sel_valid_q  <= 1'b0;
                    src_active_q <= 1'b0;
                end
            end

            if (phase_q == CYC_ADDR) begin
                src_active_q  <= 1'b0;
                inst_active_q <= 1'b0;
                if (!cmd && src_active_q) begin
                    char_addr_q <= data;
                end
            end

            if (cmd && phase_q == CYC_INST && sel_valid_q) begin
                inst_q        <= data;
                inst_active_q <= 1'b1;
            end

            for (int i = 0; i < int'(NUM_CHIPS); i++) begin
                if (exec && write_port && int'(sel_chip_q) == i) begin
                    out_q[4*i +: 4] <= data;
                end
            end
        end
    end

`ifdef RAM_RESET_CLEAR_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
            for (int i = 0; i < int'(ST_DEPTH); i++) status[i] <= '0;
        end else begin
            if (exec && write_ram) mem[mem_addr] <= data;
            if (exec && write_status) status[st_addr] <= data;
        end
    end
`else
    // No reset on the arrays so they can map onto block RAM; reset still blocks a write.
    always_ff @(posedge clock) begin
        if (!reset && exec && write_ram) mem[mem_addr] <= data;
        if (!reset && exec && write_status) status[st_addr] <= data;
    end
`endif

    assign rd_data     = ram_to_data ? mem[mem_addr] : status[st_addr];
    assign data_oe     = exec && (ram_to_data || status_to_data);
    assign data        = data_oe ? rd_data : 4'bz;
    assign bus.data_oe = data_oe;
    assign bus.out     = out_q;

endmodule

// File: doc/ram_bank.md
Name: ram_bank

Overview:
- Parametrised multi-chip successor to the single data RAM chip on the 4-bit CPU bus.
- Emulates NUM_CHIPS independent RAM chips on one shared bus. Each chip has 4 registers × 16 data characters, 4 status characters per register and a 4-bit output port.
- Implements the full RAM I/O instruction group: WRM, WMP, WR0-3, SBM, RDM, ADM, RD0-3.
- Sits beside the CPU core and ROM on the shared data bus, with cmd_n driven from the CPU's command line.

Parameters:
- NUM_CHIPS, 4, number of chips emulated (1..4); chip index i is selected by SRC data[3:2]==i.
- BANK_P0, 0, bank responds only when input p0 equals this value.
- STATUS_CHARS, 4, status characters per register (fixed to 4 for instruction decode; the parameter sizes the storage).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous active-high reset
- data  inout  4  shared CPU data bus; driven only during read execution
- sync  input  1  high during bus cycle 7; resynchronises the phase counter
- cmd_n  input  1  active-low command strobe
- p0  input  1  bank select pin
- out  output  4*NUM_CHIPS  output port latches; chip i occupies bits [4i+3:4i]
- data_oe  output  1  high when the block drives data (debug/contention check)

Behaviour:
- Reset: phase counter=0, selected chip none, reg_addr=3, char_addr=15, inst=0, src_active=0, inst_active=0, all out=0, data_oe=0, data=Z.
- Phase counter: 3-bit, increments each clock and wraps 7→0. If sync=1, the next value is 0 regardless of count.
- SRC: cmd=1 in cycle 6:
  - If p0==BANK_P0 and data[3:2]<NUM_CHIPS: chip data[3:2] becomes selected, reg_addr←data[1:0], src_active←1.
  - Otherwise the selection is cleared.
  - Next cycle 7 with cmd=0 and src_active: char_addr←data, src_active←0.
- Instruction latch: cmd=1 in cycle 4 with a chip selected: inst←data, inst_active←1. inst_active clears in cycle 7.
- Execute (cycle 6, inst_active) on the selected chip:
  - 0 WRM: mem[chip][reg][char]←data.
  - 1 WMP: out[chip]←data.
  - 4-7 WRn: status[chip][reg][n]←data.
  - 8/9/B (SBM/RDM/ADM): drive mem[chip][reg][char].
  - C-F RDn: drive status[chip][reg][n].
  - 2, 3, A, others: no action.
- data_oe=1 only during cycle 6 for read instructions; data is combinationally driven, otherwise Z.
- Simultaneous SRC and instruction in the same cycle cannot occur (distinct cycles). A new SRC replaces the selection atomically. An instruction issued with no chip selected is ignored.
- Reset mid-instruction aborts it: no write occurs and the bus is released on the same edge.
- Out-of-range chip in SRC (data[3:2]≥NUM_CHIPS) deselects the bank.

Optional Feature:
- Macro RAM_RESET_CLEAR_EN.
- Defined: reset zeroes all data and status memory (reset value 0).
- Undefined: memory is not reset, which permits block-RAM inference. Bench reads before any write are then X.
- Output port latches are always reset.

Decomposition:
- Shared package ram_pkg:
  - opcode constants OP_WRM, OP_WMP, OP_WR0..3, OP_SBM, OP_RDM, OP_ADM, OP_RD0..3
  - CYC_SRC=6, CYC_INST=4, CYC_EXEC=6, CYC_ADDR=7
  - CHAR_W=4, REG_W=2
- One sub-module, ram_bank_decode: combinational opcode → write_ram / write_port / write_status / ram_to_data / status_to_data / status_idx.

Test Plan:
- SRC data=0x6 (chip 1, reg 2), cycle 7 data=0x9; WRM data=0xA; later RDM → data=0xA in cycle 6, data_oe=1, other chips' mem[1..]unchanged.
- WR2 data=0x5 then RD2 on the same chip/reg → 0x5. RD0 → 0 with RAM_RESET_CLEAR_EN.
- WMP data=0xC to chip 3 (NUM_CHIPS=4) → out[15:12]=0xC, other nibbles 0. Reset → out=0.
- SRC with p0≠BANK_P0, then WRM → no memory change, data stays Z.
- sync pulse at counter value 3 → counter 0 next edge; subsequent SRC at the new cycle 6 accepted.
- Reset asserted in cycle 5 after WRM latch → no write; data_oe=0; the selection is cleared.
